// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the
// IF/ID pipeline register, handling stall, redirect and halt.
module instruction_fetch_stage #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INST_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
    parameter logic [INST_W-1:0]  NOP_INST = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_id_valid,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_next,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [INST_W-1:0] inst_reg;
    logic              valid_reg;
    logic [ADDR_W-1:0] id_pc_reg;
    logic [ADDR_W-1:0] id_pc_next_reg;
    logic              halted_reg;
    logic [15:0]       count_reg;

    logic [ADDR_W-1:0] pc_plus_one;

    // Unsigned ADDR_W-bit add wraps naturally from all-ones to zero.
    assign pc_plus_one = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            pc_reg         <= RESET_PC;
            inst_reg       <= NOP_INST;
            valid_reg      <= 1'b0;
            id_pc_reg      <= '0;
            id_pc_next_reg <= '0;
            halted_reg     <= 1'b0;
            count_reg      <= '0;
        end else if (redirect_valid) begin
            // Wrong-path word on imem_inst is dropped; IF/ID PC fields keep their value.
            state_reg  <= ST_RUN;
            pc_reg     <= redirect_pc;
            inst_reg   <= NOP_INST;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (halt) begin
                        state_reg  <= ST_HALT;
                        inst_reg   <= NOP_INST;
                        valid_reg  <= 1'b0;
                        halted_reg <= 1'b1;
                    end else if (!stall) begin
                        inst_reg       <= imem_inst;
                        valid_reg      <= 1'b1;
                        id_pc_reg      <= pc_reg;
                        id_pc_next_reg <= pc_plus_one;
                        pc_reg         <= pc_plus_one;
                        count_reg      <= count_reg + 16'd1;
                    end
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign imem_addr     = pc_reg;
    assign if_id_valid   = valid_reg;
    assign if_id_inst    = inst_reg;
    assign if_id_pc      = id_pc_reg;
    assign if_id_pc_next = id_pc_next_reg;
    assign halted        = halted_reg;
    assign fetch_count   = count_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios followed by
// randomized control traffic, all compared against a behavioural pipeline model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_inst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_next;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference state, as the pipeline is described architecturally.
    logic [15:0] m_pc, m_inst, m_ipc, m_ipcn, m_cnt;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_addr];

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_next  (if_id_pc_next),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic r, input logic rv, input logic [15:0] rpc,
                         input logic h, input logic s);
        reset = r; redirect_valid = rv; redirect_pc = rpc; halt = h; stall = s;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then compare.
    task automatic step(input bit verbose);
        logic [15:0] fetched;
        fetched = mem[m_pc];
        if (reset) begin
            m_pc = 16'h0000; m_inst = 16'hFFFF; m_valid = 1'b0;
            m_ipc = 16'h0000; m_ipcn = 16'h0000; m_cnt = 16'h0000; m_halted = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_inst = 16'hFFFF; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            // frozen until redirect or reset
        end else if (halt) begin
            m_inst = 16'hFFFF; m_valid = 1'b0; m_halted = 1'b1;
        end else if (!stall) begin
            m_inst = fetched; m_ipc = m_pc; m_ipcn = 16'(m_pc + 1);
            m_valid = 1'b1; m_pc = 16'(m_pc + 1); m_cnt = 16'(m_cnt + 1);
        end
        @(posedge clk);
        #1;
        check("imem_addr",     imem_addr,     m_pc);
        check("if_id_valid",   if_id_valid,   m_valid);
        check("if_id_inst",    if_id_inst,    m_inst);
        check("if_id_pc",      if_id_pc,      m_ipc);
        check("if_id_pc_next", if_id_pc_next, m_ipcn);
        check("halted",        halted,        m_halted);
        check("fetch_count",   fetch_count,   m_cnt);
        if (verbose)
            $display("t=%0t pc=%h valid=%b inst=%h id_pc=%h id_pc_next=%h halted=%b count=%0d",
                     $time, imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_next,
                     halted, fetch_count);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hFFFF; mem[1] = 16'h3301; mem[2] = 16'h3412; mem[3] = 16'h12A8;
        m_pc = '0; m_inst = '0; m_ipc = '0; m_ipcn = '0; m_cnt = '0;
        m_valid = 1'b0; m_halted = 1'b0;

        drive(1, 0, 16'h0, 0, 0);
        @(negedge clk);
        step(1);
        check("reset_inst", if_id_inst, 16'hFFFF);
        check("reset_valid", if_id_valid, 1'b0);

        // Free-running fetch of the first four words.
        drive(0, 0, 16'h0, 0, 0);
        step(1);
        check("fetch0_inst", if_id_inst, 16'hFFFF);
        check("fetch0_valid", if_id_valid, 1'b1);
        step(1); step(1); step(1);
        check("fetch3_inst", if_id_inst, 16'h12A8);
        check("fetch3_pc", if_id_pc, 16'h0003);
        check("count4", fetch_count, 16'd4);
        check("addr4", imem_addr, 16'h0004);

        // Bring (3301,1) into IF/ID, then stall 3 cycles.
        drive(0, 1, 16'h0001, 0, 0); step(1);
        drive(0, 0, 16'h0, 0, 0);    step(1);
        drive(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_inst", if_id_inst, 16'h3301);
            check("stall_pc", imem_addr, 16'h0002);
        end
        drive(0, 0, 16'h0, 0, 0); step(1);
        check("post_stall_inst", if_id_inst, 16'h3412);
        check("post_stall_pc", if_id_pc, 16'h0002);

        // Redirect together with stall.
        drive(0, 1, 16'h0010, 0, 1); step(1);
        check("redir_valid", if_id_valid, 1'b0);
        check("redir_addr", imem_addr, 16'h0010);
        drive(0, 0, 16'h0, 0, 0); step(1);
        check("redir_target_pc", if_id_pc, 16'h0010);

        // Halt, then stall toggling is ignored, then redirect out to 0.
        drive(0, 0, 16'h0, 1, 0); step(1);
        check("halt_halted", halted, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 16'h0, i[0], ~i[0]); step(1);
            check("halt_pc_hold", imem_addr, 16'h0011);
        end
        drive(0, 1, 16'h0000, 1, 1); step(1);
        check("unhalt", halted, 1'b0);
        drive(0, 0, 16'h0, 0, 0); step(1);
        check("resume_pc", if_id_pc, 16'h0000);

        // PC wrap at the top of the address space.
        drive(0, 1, 16'hFFFF, 0, 0); step(1);
        drive(0, 0, 16'h0, 0, 0);    step(1);
        check("wrap_pc", if_id_pc, 16'hFFFF);
        check("wrap_pc_next", if_id_pc_next, 16'h0000);
        step(1);
        check("wrap_pc2", if_id_pc, 16'h0000);

        // Reset during a stall at pc=7.
        drive(0, 1, 16'h0007, 0, 0); step(1);
        drive(1, 0, 16'h0, 0, 1);    step(1);
        check("rst_pc", imem_addr, 16'h0000);
        check("rst_count", fetch_count, 16'd0);

        // Randomized control traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
            step(0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
